// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: saturating-counter constants shared by the predictor and its counter
package branch_predictor_pkg;
  function automatic int cnt_weak_t(int w);
    return 1 << (w - 1);
  endfunction
  function automatic int cnt_weak_nt(int w);
    return (1 << (w - 1)) - 1;
  endfunction
endpackage

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: next value of a CNT_W-bit saturating counter (init > load > inc > dec)
module bp_sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic             init_i,
  output logic [CNT_W-1:0] cnt_o
);
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(cnt_weak_t(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(cnt_weak_nt(CNT_W));
  always_comb begin
    cnt_o = init_i ? CNT_WEAK_NT :
            load_i ? CNT_WEAK_T :
            (inc_i && !(&cnt_i)) ? cnt_i + 1'b1 :
            (dec_i && (|cnt_i)) ? cnt_i - 1'b1 : cnt_i;
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with partial tags and saturating counters, combinational lookup.
// Define BP_GSHARE_EN to XOR a global history register into the lookup index.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 6,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] lk_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  output logic [IDX_W-1:0]  pred_idx_o,
  input  logic              upd_valid_i,
  input  logic [IDX_W-1:0]  upd_idx_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i
);
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(cnt_weak_nt(CNT_W));
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
  } btb_entry_t;
  btb_entry_t       btb_q [ENTRIES];
  btb_entry_t       btb_d [ENTRIES];
  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [CNT_W-1:0] cnt_d [ENTRIES];
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] upd_tag;
  logic [CNT_W-1:0] cnt_next;
  btb_entry_t       lk_e;
  btb_entry_t       upd_e;
  logic             upd_en;
  logic             upd_hit;
  logic             unused_bits;
  assign upd_en  = upd_valid_i && start_i;
  assign upd_tag = upd_pc_i[IDX_W+2 +: TAG_W];
  assign upd_e   = btb_q[upd_idx_i];
  assign upd_hit = upd_e.valid && upd_e.tag == upd_tag;
  assign unused_bits = ^{lk_pc_i, upd_pc_i};
`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;
  always_comb begin
    ghr_d  = upd_en ? {ghr_q[GHR_W-2:0], upd_taken_i} : ghr_q;
    lk_idx = lk_pc_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
  end
  always_ff @(posedge clk_i) ghr_q <= rst_i ? '0 : ghr_d;
`else
  logic [GHR_W-1:0] unused_ghr;
  assign unused_ghr = '0;
  assign lk_idx = lk_pc_i[IDX_W+1:2];
`endif
  assign lk_e          = btb_q[lk_idx];
  assign pred_hit_o    = lk_e.valid && lk_e.tag == lk_pc_i[IDX_W+2 +: TAG_W];
  assign pred_taken_o  = start_i && pred_hit_o && cnt_q[lk_idx][CNT_W-1];
  assign pred_target_o = lk_e.target;
  assign pred_idx_o    = lk_idx;
  bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .cnt_i  (cnt_q[upd_idx_i]),
    .inc_i  (upd_hit && upd_taken_i),
    .dec_i  (upd_hit && !upd_taken_i),
    .load_i (!upd_hit && upd_taken_i),
    .init_i (1'b0),
    .cnt_o  (cnt_next)
  );
  // taken updates (hit or allocate) rewrite the whole entry; tag is unchanged on a hit
  always_comb begin
    btb_d = btb_q;
    cnt_d = cnt_q;
    if (upd_en && upd_taken_i) btb_d[upd_idx_i] = '{valid: 1'b1, tag: upd_tag, target: upd_target_i};
    if (upd_en) cnt_d[upd_idx_i] = cnt_next;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
        cnt_q[i] <= CNT_WEAK_NT;
      end
    end else begin
      btb_q <= btb_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scoreboard bench for branch_predictor in its default build
module tb_branch_predictor;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b1;
  logic [31:0] lk_pc_i = '0;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic [5:0]  pred_idx_o;
  logic        upd_valid_i = 1'b0;
  logic [5:0]  upd_idx_i = '0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        look = 1'b0;
  int          total = 0;
  int          bad = 0;
  typedef struct {
    string       name;
    logic        hit;
    logic        tk;
    logic [31:0] tgt;
    logic [5:0]  idx;
  } exp_t;
  exp_t exp_q[$];

  branch_predictor dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .lk_pc_i(lk_pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .pred_idx_o(pred_idx_o),
    .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (look) begin
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard: lookup with no expected entry");
      end else begin
        e = exp_q.pop_front();
        if (pred_hit_o !== e.hit || pred_taken_o !== e.tk || pred_idx_o !== e.idx ||
            (e.hit && pred_target_o !== e.tgt)) begin
          bad++;
          $display("FAIL %s: got hit=%0b taken=%0b tgt=%h idx=%h, want hit=%0b taken=%0b tgt=%h idx=%h",
                   e.name, pred_hit_o, pred_taken_o, pred_target_o, pred_idx_o,
                   e.hit, e.tk, e.tgt, e.idx);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    upd_valid_i  = 1'b1;
    upd_idx_i    = pc[7:2];
    upd_pc_i     = pc;
    upd_taken_i  = tk;
    upd_target_i = tg;
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    set_upd(pc, tk, tg);
    step();
    upd_valid_i = 1'b0;
  endtask

  task automatic lookup(input string n, input logic [31:0] pc, input logic h, input logic t,
                        input logic [31:0] tg);
    exp_t e;
    e.name = n;
    e.hit  = h;
    e.tk   = t;
    e.tgt  = tg;
    e.idx  = pc[7:2];
    exp_q.push_back(e);
    lk_pc_i = pc;
    look    = 1'b1;
    step();
    look    = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst_i = 1'b0;
    lookup("reset_0x40", 32'h40, 0, 0, 0);
    lookup("reset_0x1234", 32'h1234, 0, 0, 0);
    update(32'h40, 1, 32'h80);
    lookup("alloc", 32'h40, 1, 1, 32'h80);
    update(32'h40, 0, 0);
    lookup("dec_to_01", 32'h40, 1, 0, 32'h80);
    update(32'h40, 0, 0);
    update(32'h40, 0, 0);
    lookup("sat_at_00", 32'h40, 1, 0, 32'h80);
    update(32'h40, 1, 32'h80);
    lookup("inc_from_00", 32'h40, 1, 0, 32'h80);
    update(32'h40, 1, 32'h80);
    update(32'h40, 1, 32'h80);
    update(32'h40, 1, 32'h80);
    update(32'h40, 0, 0);
    lookup("sat_at_11", 32'h40, 1, 1, 32'h80);
    update(32'h40, 0, 0);
    lookup("dec_to_01b", 32'h40, 1, 0, 32'h80);
    start_i = 1'b0;
    update(32'h40, 1, 32'h999);
    update(32'h40, 1, 32'h999);
    lookup("stopped_forced_nt", 32'h40, 1, 0, 32'h80);
    start_i = 1'b1;
    lookup("stopped_frozen", 32'h40, 1, 0, 32'h80);
    update(32'h40, 1, 32'h200);
    lookup("hit_new_target", 32'h40, 1, 1, 32'h200);
    update(32'h140, 1, 32'h300);
    lookup("alias_old_miss", 32'h40, 0, 0, 0);
    lookup("alias_new_hit", 32'h140, 1, 1, 32'h300);
    update(32'h1040, 0, 32'h777);
    lookup("miss_nt_no_alloc", 32'h1040, 0, 0, 0);
    lookup("miss_nt_kept", 32'h140, 1, 1, 32'h300);
    set_upd(32'h140, 0, 0);
    lookup("same_cycle_old", 32'h140, 1, 1, 32'h300);
    upd_valid_i = 1'b0;
    lookup("same_cycle_next", 32'h140, 1, 0, 32'h300);
    set_upd(32'h140, 1, 32'h400);
    lookup("same_cycle_old_tgt", 32'h140, 1, 0, 32'h300);
    upd_valid_i = 1'b0;
    lookup("same_cycle_new_tgt", 32'h140, 1, 1, 32'h400);
    update(32'hA4, 1, 32'h600);
    lookup("other_idx", 32'hA4, 1, 1, 32'h600);
    rst_i = 1'b1;
    set_upd(32'h80, 1, 32'h500);
    step();
    upd_valid_i = 1'b0;
    rst_i = 1'b0;
    lookup("rst_clears", 32'h140, 0, 0, 0);
    lookup("rst_clears_b", 32'hA4, 0, 0, 0);
    lookup("rst_drops_upd", 32'h80, 0, 0, 0);
    step();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
